fir_tap_sequencer: RTL and testbench

FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

---
 rtl/fir_tap_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_fir_tap_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//
// Sequences the multiply-accumulate operands for a time-multiplexed FIR
// filter that uses one external multiplier and one external accumulator.
// An accepted sample goes into a circular delay line. The block then issues
// NTAPS operand pairs, newest sample first, with coef[0..NTAPS-1]. It waits
// PIPE_LAT clocks for the external pipeline, captures the running sum from
// acc_in, and presents that sum on a valid/ready output. The block performs
// no arithmetic on data values; every value passes through bit-exact.
//
// Parameters
//   NTAPS     number of taps (2..64)
//   DW        sample / coefficient / accumulator width
//   PIPE_LAT  clocks from the last operand issue to a valid sum on acc_in
//
// Optional feature
//   FIR_SAMPLE_CNT_EN  when defined, sample_cnt counts completed outputs
//                      (16 bits, wrapping). When undefined, sample_cnt is
//                      tied to 0 and no counter register exists.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   in_valid/in_ready/in_data     sample input handshake
//   coef_we/coef_addr/coef_wdata  coefficient write port (IDLE only)
//   mult_a/mult_b/op_valid/op_first  operands to the multiplier
//   acc_in                        running sum from the adder
//   out_valid/out_ready/out_data  filtered output handshake
//   sample_cnt                    completed-output count
module fir_tap_sequencer #(
  parameter int NTAPS    = 8,
  parameter int DW       = 16,
  parameter int PIPE_LAT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DW-1:0]             in_data,
  input  logic                      coef_we,
  input  logic [$clog2(NTAPS)-1:0]  coef_addr,
  input  logic [DW-1:0]             coef_wdata,
  output logic [DW-1:0]             mult_a,
  output logic [DW-1:0]             mult_b,
  output logic                      op_valid,
  output logic                      op_first,
  input  logic [DW-1:0]             acc_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DW-1:0]             out_data,
  output logic [15:0]               sample_cnt
);

  localparam int AW = $clog2(NTAPS);
  localparam int WW = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

  typedef enum logic [1:0] {IDLE, MAC, WAIT, OUT} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr;
  logic [AW-1:0] k;
  logic [WW-1:0] wcnt;
  logic          armed;
  logic [DW-1:0] x_mem    [NTAPS];
  logic [DW-1:0] coef_mem [NTAPS];
  logic [DW-1:0] a_hold, b_hold;
  logic [AW-1:0] rd_idx;
  logic [DW-1:0] a_sel, b_sel;
  logic          accept, coef_ok, k_last, wait_done;

  // armed is cleared by reset and set by the first clock edge afterwards.
  // This keeps in_ready low until one edge has passed after reset release.
  assign in_ready  = (state == IDLE) && armed;
  assign accept    = in_valid && in_ready;
  assign k_last    = (k == AW'(NTAPS - 1));
  assign wait_done = (wcnt == WW'(PIPE_LAT));
  assign coef_ok   = coef_we && (state == IDLE) &&
                     ({1'b0, coef_addr} < (AW + 1)'(NTAPS));

  // Compute (wptr - k) mod NTAPS without assuming NTAPS is a power of two.
  always_comb begin
    rd_idx = wptr - k;
    if (k > wptr) begin
      rd_idx = AW'({1'b0, wptr} + (AW + 1)'(NTAPS) - {1'b0, k});
    end
  end

  assign a_sel = x_mem[rd_idx];
  assign b_sel = coef_mem[k];

  // During MAC the operands come straight from the delay line and the
  // coefficient table. A coefficient written on the accepting edge is
  // therefore already visible to the first read. In every other state the
  // operands hold the last pair that was issued.
  assign op_valid = (state == MAC);
  assign op_first = (state == MAC) && (k == '0);
  assign mult_a   = op_valid ? a_sel : a_hold;
  assign mult_b   = op_valid ? b_sel : b_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = MAC;
      MAC:     if (k_last)    state_nxt = WAIT;
      WAIT:    if (wait_done) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // WAIT spans PIPE_LAT+1 edges. acc_in is captured on the last of them,
  // so out_valid rises NTAPS+PIPE_LAT+1 edges after the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      k         <= '0;
      wcnt      <= '0;
      armed     <= 1'b0;
      a_hold    <= '0;
      b_hold    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      for (int i = 0; i < NTAPS; i++) begin
        x_mem[i]    <= '0;
        coef_mem[i] <= '0;
      end
    end else begin
      armed <= 1'b1;
      if (coef_ok) begin
        coef_mem[coef_addr] <= coef_wdata;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            x_mem[wptr] <= in_data;
            k           <= '0;
          end
        end
        MAC: begin
          a_hold <= a_sel;
          b_hold <= b_sel;
          if (k_last) begin
            wcnt <= '0;
          end else begin
            k <= k + 1'b1;
          end
        end
        WAIT: begin
          if (wait_done) begin
            out_data  <= acc_in;
            out_valid <= 1'b1;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            wptr      <= (wptr == AW'(NTAPS - 1)) ? '0 : wptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FIR_SAMPLE_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sample_cnt = cnt_q;
`else
  assign sample_cnt = '0;
`endif

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// tb_fir_tap_sequencer
//
// Drives fir_tap_sequencer (NTAPS=4, PIPE_LAT=2, DW=16) with directed and
// randomized samples. Expected values come from a behavioural model:
//   - a newest-first sample history
//   - a coefficient table
//   - a completed-output counter
// acc_in carries the model's FIR sum only in the cycle before the expected
// capture edge and carries a differing value at all other times.
module tb_fir_tap_sequencer;

  localparam int NT = 4;
  localparam int PL = 2;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          clk_run = 1'b0;
  logic          rst;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          coef_we = 1'b0;
  logic [1:0]    coef_addr = '0;
  logic [DW-1:0] coef_wdata = '0;
  logic [DW-1:0] mult_a, mult_b;
  logic          op_valid, op_first;
  logic [DW-1:0] acc_in = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [15:0]   sample_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] m_coef [NT];
  logic [DW-1:0] m_hist [NT];
  int            m_cnt;

  fir_tap_sequencer #(.NTAPS(NT), .DW(DW), .PIPE_LAT(PL)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .mult_a     (mult_a),
    .mult_b     (mult_b),
    .op_valid   (op_valid),
    .op_first   (op_first),
    .acc_in     (acc_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .sample_cnt (sample_cnt)
  );

  // Stoppable clock, so that reset can be applied with the clock frozen.
  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] expCnt();
`ifdef FIR_SAMPLE_CNT_EN
    return 16'(m_cnt);
`else
    return 16'h0;
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NT; i++) begin
      m_coef[i] = '0;
      m_hist[i] = '0;
    end
    m_cnt = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_op_valid"},  op_valid,   0);
    checkOutput({tag, "_op_first"},  op_first,   0);
    checkOutput({tag, "_mult_a"},    mult_a,     0);
    checkOutput({tag, "_mult_b"},    mult_b,     0);
    checkOutput({tag, "_out_valid"}, out_valid,  0);
    checkOutput({tag, "_out_data"},  out_data,   0);
    checkOutput({tag, "_in_ready"},  in_ready,   0);
    checkOutput({tag, "_cnt"},       sample_cnt, 0);
  endtask

  // Starts and ends at a falling edge, with the DUT in IDLE.
  task automatic writeCoef(input logic [1:0] addr, input logic [DW-1:0] data);
    coef_we    = 1'b1;
    coef_addr  = addr;
    coef_wdata = data;
    @(posedge clk);
    #1 coef_we = 1'b0;
    m_coef[addr] = data;
    @(negedge clk);
  endtask

  // One full sample transaction. It starts and ends at a falling edge, with
  // the DUT in IDLE.
  //   cw    : coefficient write on the accepting edge
  //   hold  : cycles out_ready is held low
  //   ocw   : attempt a coefficient write to addr 0 while stalled in OUT
  task automatic applyStimulus(input logic [DW-1:0] sample, input bit cw,
                               input logic [1:0] cw_addr, input logic [DW-1:0] cw_data,
                               input int hold, input bit ocw);
    logic [DW-1:0] exp_a [NT];
    logic [DW-1:0] exp_b [NT];
    logic [DW-1:0] sum;
    checkOutput("idle_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = sample;
    if (cw) begin
      coef_we    = 1'b1;
      coef_addr  = cw_addr;
      coef_wdata = cw_data;
      m_coef[cw_addr] = cw_data;
    end
    for (int i = NT - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = sample;
    sum = '0;
    for (int i = 0; i < NT; i++) begin
      exp_a[i] = m_hist[i];
      exp_b[i] = m_coef[i];
      sum = sum + exp_a[i] * exp_b[i];
    end
    acc_in = sum ^ 16'($urandom_range(1, 65535));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    for (int c = 0; c <= NT + PL; c++) begin
      @(negedge clk);
      if (c < NT) begin
        checkOutput("op_valid", op_valid, 1);
        checkOutput("op_first", op_first, (c == 0) ? 1 : 0);
        checkOutput("mult_a",   mult_a,   exp_a[c]);
        checkOutput("mult_b",   mult_b,   exp_b[c]);
      end else begin
        checkOutput("wait_op_valid", op_valid, 0);
        checkOutput("wait_op_first", op_first, 0);
        checkOutput("wait_mult_a",   mult_a,   exp_a[NT-1]);
        checkOutput("wait_mult_b",   mult_b,   exp_b[NT-1]);
      end
      checkOutput("early_out_valid", out_valid, 0);
      checkOutput("busy_in_ready",   in_ready,  0);
      acc_in = (c == NT + PL) ? sum : (sum ^ 16'($urandom_range(1, 65535)));
      @(posedge clk);
    end
    @(negedge clk);
    acc_in = sum ^ 16'($urandom_range(1, 65535));
    checkOutput("out_valid_rise", out_valid, 1);
    checkOutput("out_data",       out_data,  sum);
    checkOutput("out_op_valid",   op_valid,  0);
    checkOutput("out_in_ready",   in_ready,  0);
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      if (ocw) begin
        coef_we    = 1'b1;
        coef_addr  = 2'd0;
        coef_wdata = 16'hBEEF;
      end
      @(posedge clk);
      @(negedge clk);
      coef_we = 1'b0;
      checkOutput("stall_out_valid", out_valid, 1);
      checkOutput("stall_out_data",  out_data,  sum);
      checkOutput("stall_in_ready",  in_ready,  0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    m_cnt++;
    @(negedge clk);
    checkOutput("done_out_valid", out_valid,  0);
    checkOutput("done_in_ready",  in_ready,   1);
    checkOutput("sample_cnt",     sample_cnt, expCnt());
  endtask

  // Reset pulse while the DUT is issuing tap k=2, applied with the clock
  // stopped.
  task automatic midMacReset();
    checkOutput("mr_in_ready", in_ready, 1);
    in_valid = 1'b1;
    in_data  = 16'h1234;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk);
    end
    @(negedge clk);
    checkOutput("mr_k2_op_valid", op_valid, 1);
    clk_run = 1'b0;
    #2 rst = 1'b1;
    #1 checkResetOutputs("mr");
    #10 rst = 1'b0;
    #1 checkOutput("mr_ready_pre_edge", in_ready, 0);
    clk_run = 1'b1;
    modelReset();
    repeat (NT + PL + 2) begin
      @(negedge clk);
      checkOutput("mr_no_out_valid", out_valid, 0);
    end
    checkOutput("mr_ready_post", in_ready, 1);
  endtask

  initial begin
    rst = 1'b0;
    #1 rst = 1'b1;
    #2 checkResetOutputs("por");
    clk_run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("rst_held");
    rst = 1'b0;
    #1 checkOutput("ready_pre_edge", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("ready_post_edge", in_ready, 1);
    modelReset();

    // Directed: coefficients 1..4, then a single sample 5.
    writeCoef(2'd0, 16'd1);
    writeCoef(2'd1, 16'd2);
    writeCoef(2'd2, 16'd3);
    writeCoef(2'd3, 16'd4);
    applyStimulus(16'h0005, 1'b0, 2'd0, 16'd0, 0, 1'b0);

    // Samples 1..5 exercise the delay-line wrap.
    for (int s = 1; s <= 5; s++) begin
      applyStimulus(16'(s), 1'b0, 2'd0, 16'd0, s % 2, 1'b0);
    end

    // A long stall in OUT, with a coefficient write that must be ignored.
    applyStimulus(16'h0033, 1'b0, 2'd0, 16'd0, 10, 1'b1);
    applyStimulus(16'h0011, 1'b0, 2'd0, 16'd0, 0, 1'b0);

    // Randomized traffic, including coefficient writes on the accepting edge.
    for (int n = 0; n < 16; n++) begin
      repeat ($urandom_range(0, 2)) writeCoef(2'($urandom), 16'($urandom));
      applyStimulus(16'($urandom), 1'($urandom_range(0, 1)), 2'($urandom),
                    16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    midMacReset();
    applyStimulus(16'h0009, 1'b0, 2'd0, 16'd0, 0, 1'b0);
    applyStimulus(16'($urandom), 1'b1, 2'd1, 16'h0007, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
